emio_gpio_conditioner: RTL
==========================

// Module: emio_gpio_conditioner
// PURPOSE
//   PL-side conditioner between the PS7 EMIO GPIO bank (GPIO_I/O/T) and the FMC pins.
//   Per channel: input synchroniser, debounce filter, edge detect, sticky interrupt status.
//   Outputs: registered output/tristate pass-through.
//   Generalises the fixed 6-bit EMIO pass-through to NUM_CH channels and adds one combined level IRQ.
//   The IRQ is routed to PS7 IRQ_F2P.
// PARAMETERS
//   NUM_CH           6     number of GPIO channels (1..64)
//   SYNC_STAGES      2     input synchroniser depth (>=2)
//   DEBOUNCE_CYCLES  1000  consecutive stable cycles before input accepted; 0 = bypass
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1) debounce counter width (derived, do not override)
// PORTS
//   clk          in   1       FCLK_CLK0-domain clock
//   rst          in   1       synchronous, active-high reset
//   ps_gpio_o    in   NUM_CH  PS GPIO_O (drive value)
//   ps_gpio_t    in   NUM_CH  PS GPIO_T (1 = hi-Z)
//   ps_gpio_i    out  NUM_CH  debounced pin value to PS GPIO_I
//   pin_i        in   NUM_CH  raw pad input from IOBUF (asynchronous)
//   pin_o        out  NUM_CH  pad drive value to IOBUF
//   pin_t        out  NUM_CH  pad tristate to IOBUF (1 = hi-Z)
//   rise_en      in   NUM_CH  per-channel: rising edge sets status
//   fall_en      in   NUM_CH  per-channel: falling edge sets status
//   irq_mask     in   NUM_CH  per-channel: 1 = masked from irq
//   irq_clr      in   NUM_CH  per-channel clear pulse for irq_status
//   irq_status   out  NUM_CH  sticky edge status
//   irq          out  1       level IRQ = registered |(irq_status & ~irq_mask)
// BEHAVIOUR
//   Reset values: pin_o=0, pin_t=all 1 (hi-Z), ps_gpio_i=0, irq_status=0, irq=0, sync chain=0, counters=0.
//   Output path: pin_o<=ps_gpio_o, pin_t<=ps_gpio_t; 1-cycle latency; no other modification.
//   Sync: pin_i through SYNC_STAGES flops -> s (s = last stage).
//   Debounce, per channel, on stable register d (drives ps_gpio_i):
//     - s==d: cnt<=0.
//     - s!=d and cnt==DEBOUNCE_CYCLES-1: d<=s, cnt<=0.
//     - else: cnt<=cnt+1.
//     - A glitch shorter than DEBOUNCE_CYCLES never changes d; a counter restart on return to d is required.
//     - DEBOUNCE_CYCLES=0: d<=s every cycle.
//   Latency: pad edge to ps_gpio_i = SYNC_STAGES+DEBOUNCE_CYCLES cycles (SYNC_STAGES+1 in bypass).
//   Edge detect on d transitions (registered compare of d vs d_prev):
//     - 0->1 with rise_en: status set.
//     - 1->0 with fall_en: status set.
//     - Status is set the cycle after d changes.
//   irq_status: sticky until irq_clr bit seen; set and clear in same cycle -> set wins (no lost edge).
//   irq: registered, 1 cycle after irq_status; masking does not clear status (unmask re-asserts irq).
//   Enables/mask changes take effect next cycle; enabling an edge does not report past transitions.
//   Readback: input path reads pin_i regardless of pin_t (driven pads loop back via IOBUF).
//   Reset mid-debounce: counter, d and status all cleared; no edge reported for the reset transition.
// STRUCTURE
//   Package emio_gpio_pkg:
//     - NUM_CH_MAX=64;
//     - function clog2_cnt(DEBOUNCE_CYCLES);
//     - typedef edge_cfg_t {rise_en, fall_en}.
//   Sub-module gpio_debounce_ch: one channel of sync + debounce + edge detect.
//     - Outputs d, rise_pulse, fall_pulse.
//     - Instantiated NUM_CH times via generate.
//   Top holds the output registers, irq_status and irq reduction.
// TESTING (bench: NUM_CH=6, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//   1. rst held 3 cycles, ps_gpio_t=6'h00 -> pin_t=6'h3F, pin_o=0, irq=0 until 1 cycle after rst falls; then pin_t=6'h00.
//   2. pin_i[0] 0->1, held -> ps_gpio_i[0]=1 exactly 6 cycles later; rise_en[0]=1 -> irq_status[0]=1 at +7, irq=1 at +8.
//   3. pin_i[1] 1-cycle and 3-cycle glitches -> ps_gpio_i[1] stays 0, irq_status[1]=0.
//   4. fall_en[2]=1, rise_en[2]=0, pin_i[2] toggles 0->1->0 (10 cycles each) -> status[2] set only after falling edge.
//   5. irq_clr[0] pulsed in the same cycle a new edge sets status[0] -> status[0] remains 1; clr alone later -> 0, irq drops next cycle.
//   6. irq_mask[0]=1 with status[0]=1 -> irq=0; mask cleared -> irq=1 next cycle; rst mid-debounce on ch3 -> no status, ps_gpio_i[3]=0.

Source files
------------

// File: rtl/emio_gpio_pkg.sv
// Shared types and helpers for the EMIO GPIO conditioner.
// Width helper keeps the debounce counter at least one bit wide in bypass mode.
package emio_gpio_pkg;

   localparam int NUM_CH_MAX = 64;

   typedef struct packed {
      logic rise_en;
      logic fall_en;
   } edge_cfg_t;

   function automatic int clog2_cnt(input int debounce_cycles);
      int w;
      w = $clog2(debounce_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/gpio_debounce_ch.sv
// One GPIO input channel: synchroniser, debounce filter and edge pulses.
// Pulses are high for the single cycle after the stable value d changes.
module gpio_debounce_ch
   import emio_gpio_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int CNT_W           = clog2_cnt(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic d,
   output logic rise_pulse,
   output logic fall_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   d_q;
   logic                   d_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk) begin
            if (rst) begin
               d_q <= 1'b0;
            end else begin
               d_q <= s;
            end
         end
      end else begin : g_filter
         localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
         logic [CNT_W-1:0] cnt_q;

         // Counter restarts whenever s returns to d, so split glitches never accumulate.
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q <= '0;
               d_q   <= 1'b0;
            end else if (s == d_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_TC) begin
               d_q   <= s;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         d_prev_q <= 1'b0;
      end else begin
         d_prev_q <= d_q;
      end
   end

   assign d          = d_q;
   assign rise_pulse = d_q & ~d_prev_q;
   assign fall_pulse = ~d_q & d_prev_q;

endmodule

// File: rtl/emio_gpio_conditioner.sv
// PL-side conditioner between the PS7 EMIO GPIO bank and FMC pads.
// Registered output pass-through, filtered inputs, sticky edge status and one level IRQ.
module emio_gpio_conditioner
   import emio_gpio_pkg::*;
#(
   parameter int NUM_CH          = 6,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ps_gpio_o,
   input  logic [NUM_CH-1:0] ps_gpio_t,
   output logic [NUM_CH-1:0] ps_gpio_i,
   input  logic [NUM_CH-1:0] pin_i,
   output logic [NUM_CH-1:0] pin_o,
   output logic [NUM_CH-1:0] pin_t,
   input  logic [NUM_CH-1:0] rise_en,
   input  logic [NUM_CH-1:0] fall_en,
   input  logic [NUM_CH-1:0] irq_mask,
   input  logic [NUM_CH-1:0] irq_clr,
   output logic [NUM_CH-1:0] irq_status,
   output logic              irq
);

   localparam int CNT_W = clog2_cnt(DEBOUNCE_CYCLES);

   edge_cfg_t         edge_cfg [NUM_CH];
   logic [NUM_CH-1:0] d_vec;
   logic [NUM_CH-1:0] rise_vec;
   logic [NUM_CH-1:0] fall_vec;
   logic [NUM_CH-1:0] set_vec;
   logic [NUM_CH-1:0] status_q;
   logic              irq_q;

   generate
      for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
         gpio_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .pin_i      (pin_i[ch]),
            .d          (d_vec[ch]),
            .rise_pulse (rise_vec[ch]),
            .fall_pulse (fall_vec[ch])
         );

         assign edge_cfg[ch] = '{rise_en: rise_en[ch], fall_en: fall_en[ch]};
         assign set_vec[ch]  = (rise_vec[ch] & edge_cfg[ch].rise_en) |
                               (fall_vec[ch] & edge_cfg[ch].fall_en);
      end
   endgenerate

   // Set has priority over clear so an edge landing with a clear pulse is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         pin_o    <= '0;
         pin_t    <= '1;
         status_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         pin_o    <= ps_gpio_o;
         pin_t    <= ps_gpio_t;
         status_q <= (status_q & ~irq_clr) | set_vec;
         irq_q    <= |(status_q & ~irq_mask);
      end
   end

   assign ps_gpio_i  = d_vec;
   assign irq_status = status_q;
   assign irq        = irq_q;

endmodule
